// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO in front of the shifter.
//
// Each frame is a start bit (0), eight data bits LSB first, and a stop bit (1).
// Every bit lasts CLKS_PER_BIT clocks. Frames run back to back with no idle gap
// while the FIFO has bytes waiting.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous reset, ACTIVE-HIGH despite its name (1 = reset)
//   tx_data    : byte to enqueue
//   tx_valid   : producer request; a write happens on an edge where tx_valid && tx_ready
//   tx_ready   : FIFO has room and the block is out of reset (combinational)
//   sci_tx     : serial line, driven straight from a flop, idles at 1
//   tx_busy    : registered, 1 while a frame is on the line
//   fifo_count : bytes waiting in the FIFO, excluding the byte being shifted
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          sci_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    state_t            state_r;
    logic [BAUD_W-1:0] baud_cnt_r;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        shift_r;
    logic              sci_r;
    logic              busy_r;

    logic              ready_s;
    logic              push_s;
    logic              pop_s;
    logic              have_data_s;
    logic              bit_end_s;
    logic [7:0]        head_s;

    // FIFO handshake and the FSM's pop decision; the pop condition mirrors
    // exactly the FSM branches that load a new byte into the shifter.
    always_comb begin
        have_data_s = (count_r != CNT_ZERO);
        bit_end_s   = (baud_cnt_r == BAUD_LAST);
        head_s      = mem_r[rd_ptr_r];
        // rst_n is active-high: ready only when out of reset and not full.
        if (rst_n) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (count_r < DEPTH_C);
        end
        push_s = tx_valid && ready_s;
        case (state_r)
            ST_IDLE: pop_s = have_data_s;
            ST_STOP: pop_s = have_data_s && bit_end_s;
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Transmit FSM; sci_tx and tx_busy come straight from these flops.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {BAUD_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            sci_r      <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sci_r      <= 1'b1;
                    busy_r     <= 1'b0;
                    baud_cnt_r <= {BAUD_W{1'b0}};
                    if (have_data_s) begin
                        shift_r <= head_s;
                        sci_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        sci_r      <= shift_r[0];
                        bit_cnt_r  <= 3'd0;
                        state_r    <= ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        if (bit_cnt_r == 3'd7) begin
                            sci_r   <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            // shift_r[1] is the bit that becomes shift_r[0] after this shift.
                            shift_r   <= {1'b0, shift_r[7:1]};
                            sci_r     <= shift_r[1];
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        if (have_data_s) begin
                            // Chain straight into the next start bit: no idle gap.
                            shift_r <= head_s;
                            sci_r   <= 1'b0;
                            state_r <= ST_START;
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sci_r   <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready   = ready_s;
    assign sci_tx     = sci_r;
    assign tx_busy    = busy_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Three instances share clock,
// reset and tx_data: CLKS_PER_BIT = 8, 2 and the default 5208. Written bytes
// go into a scoreboard queue; a line receiver decodes frames on the selected
// instance and compares each decoded byte with the queue head.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic [2:0] valid_v;
    wire  [2:0] ready_v;
    wire  [2:0] sci_v;
    wire  [2:0] busy_v;
    wire  [2:0] cnt0, cnt1, cnt2;

    int checks = 0;
    int errors = 0;
    int sel    = 0;
    logic rx_en = 1'b0;
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) u8 (
        .clk(clk), .rst_n(rst), .tx_data(tx_data), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .sci_tx(sci_v[0]), .tx_busy(busy_v[0]), .fifo_count(cnt0));
    uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst), .tx_data(tx_data), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .sci_tx(sci_v[1]), .tx_busy(busy_v[1]), .fifo_count(cnt1));
    uart_tx #(.FIFO_DEPTH(4)) ud (
        .clk(clk), .rst_n(rst), .tx_data(tx_data), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .sci_tx(sci_v[2]), .tx_busy(busy_v[2]), .fifo_count(cnt2));

    function automatic int cpb_of(input int s);
        case (s)
            0:       return 8;
            1:       return 2;
            default: return 5208;
        endcase
    endfunction

    function automatic logic [2:0] cnt_of(input int s);
        case (s)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Scoreboard push: every accepted write, in order.
    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (valid_v[s] && ready_v[s]) sb_q.push_back(tx_data);
            end
        end
    end

    // Line receiver: samples mid-bit, checks framing, pops scoreboard.
    initial begin : rx_proc
        int s, c;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && !rst && sci_v[sel] == 1'b0) begin
                s = sel;
                c = cpb_of(s);
                repeat (c / 2) @(negedge clk);
                chk("rx_start", 32'(sci_v[s]), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (c) @(negedge clk);
                    b[i] = sci_v[s];
                end
                repeat (c) @(negedge clk);
                chk("rx_stop", 32'(sci_v[s]), 32'd1);
                if (sb_q.size() == 0) begin
                    chk("rx_unexpected_frame", 32'(b), 32'hFFFF_FFFF);
                end else begin
                    chk("rx_byte", 32'(b), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    // One write cycle; called just after a falling edge, returns after the next one.
    task automatic put(input int s, input logic [7:0] d);
        tx_data    = d;
        valid_v[s] = 1'b1;
        @(negedge clk);
        valid_v[s] = 1'b0;
    endtask

    // Single frame into an idle instance: latency, per-bit levels, busy fall time.
    task automatic send_and_check(input int s, input logic [7:0] d, input logic [9:0] frame);
        int c;
        c = cpb_of(s);
        put(s, d);
        chk("lat_cnt1", 32'(cnt_of(s)), 32'd1);
        chk("lat_idle", 32'(sci_v[s]), 32'd1);
        @(negedge clk);
        chk("lat_start", 32'(sci_v[s]), 32'd0);
        chk("lat_busy", 32'(busy_v[s]), 32'd1);
        chk("lat_cnt0", 32'(cnt_of(s)), 32'd0);
        repeat (c / 2) @(negedge clk);
        chk("bit0", 32'(sci_v[s]), 32'(frame[0]));
        for (int i = 1; i < 10; i++) begin
            repeat (c) @(negedge clk);
            chk($sformatf("bit%0d", i), 32'(sci_v[s]), 32'(frame[i]));
        end
        repeat (c - 1 - c / 2) @(negedge clk);
        chk("busy_last", 32'(busy_v[s]), 32'd1);
        @(negedge clk);
        chk("busy_fall", 32'(busy_v[s]), 32'd0);
        chk("idle_line", 32'(sci_v[s]), 32'd1);
    endtask

    task automatic wait_drain(input int s, input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy_v[s] !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // frame[0]=start ... frame[9]=stop
    } vec_t;

    vec_t vecs [5];

    initial begin : main
        int gaps, lows, highs, d;
        logic acc, saw_full, full_bad;
        vecs[0] = '{8'h42, {1'b1, 8'h42, 1'b0}};
        vecs[1] = '{8'h55, {1'b1, 8'h55, 1'b0}};
        vecs[2] = '{8'hA3, {1'b1, 8'hA3, 1'b0}};
        vecs[3] = '{8'h00, {1'b1, 8'h00, 1'b0}};
        vecs[4] = '{8'h81, {1'b1, 8'h81, 1'b0}};

        rst     = 1'b1;
        tx_data = 8'h00;
        valid_v = 3'b000;

        // Reset held for 10 cycles.
        repeat (10) @(negedge clk);
        chk("rst_sci", 32'(sci_v[0]), 32'd1);
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_ready", 32'(ready_v[0]), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ready_v[0]), 32'd1);
        chk("post_rst_cnt", 32'(cnt0), 32'd0);
        chk("post_rst_sci", 32'(sci_v[0]), 32'd1);
        @(negedge clk);
        rx_en = 1'b1;

        // Table: single frames at CLKS_PER_BIT = 8.
        sel = 0;
        for (int v = 0; v < 5; v++) send_and_check(0, vecs[v].data, vecs[v].frame);

        // Back-to-back frames: 0x55, 0xA3, 0x00 on consecutive edges.
        put(0, 8'h55);
        chk("b2b_cnt_a", 32'(cnt0), 32'd1);
        put(0, 8'hA3);
        chk("b2b_cnt_b", 32'(cnt0), 32'd1);
        chk("b2b_start1", 32'(sci_v[0]), 32'd0);
        put(0, 8'h00);
        chk("b2b_cnt_c", 32'(cnt0), 32'd2);
        gaps = 0;
        for (int c = 2; c <= 240; c++) begin
            @(negedge clk);
            if (c < 240 && busy_v[0] !== 1'b1) gaps++;
            if (c == 79)  chk("b2b_stop1", 32'(sci_v[0]), 32'd1);
            if (c == 80)  begin chk("b2b_start2", 32'(sci_v[0]), 32'd0); chk("b2b_cnt_d", 32'(cnt0), 32'd1); end
            if (c == 160) begin chk("b2b_start3", 32'(sci_v[0]), 32'd0); chk("b2b_cnt_e", 32'(cnt0), 32'd0); end
            if (c == 240) chk("b2b_busy_fall", 32'(busy_v[0]), 32'd0);
        end
        chk("b2b_busy_gaps", 32'(gaps), 32'd0);
        wait_drain(0, 200);

        // Full FIFO: stream 0x01..0x08 with tx_valid held high.
        d = 1; saw_full = 1'b0; full_bad = 1'b0;
        while (d <= 8) begin
            tx_data    = 8'(d);
            valid_v[0] = 1'b1;
            acc        = ready_v[0];
            if (cnt0 == 3'd4) begin
                saw_full = 1'b1;
                if (ready_v[0] !== 1'b0) full_bad = 1'b1;
            end
            @(negedge clk);
            if (acc) d++;
        end
        valid_v[0] = 1'b0;
        chk("full_seen", 32'(saw_full), 32'd1);
        chk("full_ready_low", 32'(full_bad), 32'd0);
        wait_drain(0, 1200);

        // Push and pop on the STOP-end edge with two bytes waiting.
        put(0, 8'hC1);
        put(0, 8'hC2);
        put(0, 8'hC3);
        chk("pp_cnt_before", 32'(cnt0), 32'd2);
        repeat (78) @(negedge clk);
        put(0, 8'hC4);
        chk("pp_cnt_after", 32'(cnt0), 32'd2);
        chk("pp_next_start", 32'(sci_v[0]), 32'd0);
        wait_drain(0, 600);

        // CLKS_PER_BIT = 2, byte 0xFF: 2 cycles low then 18 cycles high.
        sel = 1;
        @(negedge clk);
        put(1, 8'hFF);
        lows = 0; highs = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j < 2 && sci_v[1] === 1'b0) lows++;
            if (j >= 2 && sci_v[1] === 1'b1 && busy_v[1] === 1'b1) highs++;
        end
        chk("cpb2_low", 32'(lows), 32'd2);
        chk("cpb2_high", 32'(highs), 32'd18);
        @(negedge clk);
        chk("cpb2_busy_fall", 32'(busy_v[1]), 32'd0);
        wait_drain(1, 50);

        // Default bit time: 0x42.
        sel = 2;
        @(negedge clk);
        send_and_check(2, 8'h42, {1'b1, 8'h42, 1'b0});
        wait_drain(2, 10);

        // Asynchronous reset in the middle of a data bit.
        rx_en = 1'b0;
        sel   = 0;
        @(negedge clk);
        put(0, 8'h00);
        put(0, 8'h33);
        repeat (30) @(negedge clk);
        chk("mid_pre_low", 32'(sci_v[0]), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_sci", 32'(sci_v[0]), 32'd1);
        chk("mid_rst_cnt", 32'(cnt0), 32'd0);
        chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        chk("mid_rst_ready", 32'(ready_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (sci_v[0] !== 1'b1 || busy_v[0] !== 1'b0) lows++;
        end
        chk("mid_rst_discard", 32'(lows), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
